// File: rtl/inst_fetch_unit.sv
// Instruction fetch: owns the PC and fetches one aligned 64-bit block per request; the buffer fills one cycle after Imem_Rvalid.
// New requests wait until the buffer frees (Stall holds it); a flush clears the buffer and a response that a flush made stale is dropped.
module inst_fetch_unit #(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Inst_Req,
  input  logic              Stall,
  input  logic              Branch_Flush,
  input  logic [2:0]        PCsrcSel,
  input  logic [ADDR_W-1:0] Branch_Target,
  output logic              Imem_Req,
  output logic [ADDR_W-1:0] Imem_Addr,
  input  logic              Imem_Gnt,
  input  logic              Imem_Rvalid,
  input  logic [63:0]       Imem_Rdata,
  output logic              Inst_Ready,
  output logic [31:0]       Inst0,
  output logic [31:0]       Inst1,
  output logic              Inst0_Valid,
  output logic              Inst1_Valid,
  output logic [ADDR_W-1:0] Inst_PC
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-4:0] blk_next;
  logic              buf_free;
  logic              load;

  assign buf_free  = !Inst_Ready || !Stall;
  assign Imem_Req  = !rst && (state == S_REQ) && Inst_Req && buf_free && !Branch_Flush;
  assign Imem_Addr = {pc[ADDR_W-1:3], 3'b000};
  assign blk_next  = pc[ADDR_W-1:3] + {{(ADDR_W-4){1'b0}}, 1'b1};
  assign load      = (state == S_WAIT) && Imem_Rvalid && !Branch_Flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      Inst_Ready  <= 1'b0;
      Inst0       <= '0;
      Inst1       <= '0;
      Inst0_Valid <= 1'b0;
      Inst1_Valid <= 1'b0;
      Inst_PC     <= RESET_PC;
    end else if (Branch_Flush) begin
      Inst_Ready  <= 1'b0;
      Inst0_Valid <= 1'b0;
      Inst1_Valid <= 1'b0;
      if (PCsrcSel == 3'b001) pc <= Branch_Target;
      // An outstanding fetch that has not returned yet must be drained before re-issuing.
      state <= (state == S_REQ || Imem_Rvalid) ? S_REQ : S_DRAIN;
    end else begin
      case (state)
        S_REQ:   if (Imem_Req && Imem_Gnt) state <= S_WAIT;
        S_WAIT: begin
          if (Imem_Rvalid) begin
            pc    <= {blk_next, 3'b000};
            state <= S_REQ;
          end
        end
        S_DRAIN: if (Imem_Rvalid) state <= S_REQ;
        default: state <= S_REQ;
      endcase

      if (load) begin
        Inst_Ready  <= 1'b1;
        Inst0       <= Imem_Rdata[31:0];
        Inst1       <= Imem_Rdata[63:32];
        Inst0_Valid <= !pc[2];
        Inst1_Valid <= 1'b1;
        Inst_PC     <= pc;
      end else if (Inst_Ready && !Stall) begin
        Inst_Ready  <= 1'b0;
        Inst0_Valid <= 1'b0;
        Inst1_Valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomised bench for inst_fetch_unit: a memory model plus an architectural PC model feed a scoreboard
// queue of expected fetch blocks; a separate monitor pops and compares whenever the buffer is loaded.
module tb_inst_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Inst_Req = 1'b0, Stall = 1'b0, Branch_Flush = 1'b0;
  logic [2:0]  PCsrcSel = 3'b000;
  logic [31:0] Branch_Target = '0;
  logic        Imem_Req;
  logic [31:0] Imem_Addr;
  logic        Imem_Gnt = 1'b0, Imem_Rvalid = 1'b0;
  logic [63:0] Imem_Rdata = '0;
  logic        Inst_Ready;
  logic [31:0] Inst0, Inst1;
  logic        Inst0_Valid, Inst1_Valid;
  logic [31:0] Inst_PC;

  always #5 clk = ~clk;

  inst_fetch_unit #(.ADDR_W(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .Inst_Req(Inst_Req), .Stall(Stall), .Branch_Flush(Branch_Flush),
    .PCsrcSel(PCsrcSel), .Branch_Target(Branch_Target), .Imem_Req(Imem_Req), .Imem_Addr(Imem_Addr),
    .Imem_Gnt(Imem_Gnt), .Imem_Rvalid(Imem_Rvalid), .Imem_Rdata(Imem_Rdata), .Inst_Ready(Inst_Ready),
    .Inst0(Inst0), .Inst1(Inst1), .Inst0_Valid(Inst0_Valid), .Inst1_Valid(Inst1_Valid), .Inst_PC(Inst_PC)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] i0;
    logic [31:0] i1;
    logic        v0;
  } blk_t;

  blk_t q[$];
  blk_t cur;
  int   n_cmp = 0;
  int   n_fail = 0;

  // Stimulus knobs
  bit          k_rst = 1'b1, k_req = 1'b0, k_stall = 1'b0, k_rand = 1'b0, k_fixed = 1'b0;
  bit          k_flush_next = 1'b0, k_flush_at_rv = 1'b0;
  logic [2:0]  k_sel = 3'b001;
  logic [31:0] k_tgt = '0;
  logic [63:0] k_data = '0;
  int          k_gnt_pct = 100, k_lat_min = 1, k_lat_max = 1;

  // Reference model: architectural PC, one outstanding fetch, buffer occupancy
  logic [31:0] exp_pc = RST_PC;
  bit          pending = 1'b0, pend_stale = 1'b0, mbuf = 1'b0, last_grant = 1'b0;
  int          pend_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    bit          rv, fl, exp_req, accepted;
    logic [2:0]  sel;
    logic [31:0] tgt;
    logic [63:0] d;
    @(negedge clk);
    rv = 1'b0;
    if (pending) begin
      if (pend_cnt == 0) rv = 1'b1;
      else pend_cnt--;
    end
    d   = k_fixed ? k_data : {$urandom, $urandom};
    fl  = 1'b0;
    sel = k_sel;
    tgt = k_tgt;
    if (k_flush_next) begin fl = 1'b1; k_flush_next = 1'b0; end
    if (k_flush_at_rv && rv) begin fl = 1'b1; k_flush_at_rv = 1'b0; end
    if (k_rand) begin
      Inst_Req = ($urandom_range(99) < 90);
      Stall    = ($urandom_range(99) < 30);
      if ($urandom_range(99) < 6) begin
        fl  = 1'b1;
        sel = ($urandom_range(1) == 1) ? 3'b001 : 3'($urandom_range(7));
        tgt = $urandom & 32'hFFFF_FFFC;
      end
    end else begin
      Inst_Req = k_req;
      Stall    = k_stall;
    end
    rst           = k_rst;
    Branch_Flush  = fl;
    PCsrcSel      = sel;
    Branch_Target = tgt;
    Imem_Gnt      = ($urandom_range(99) < k_gnt_pct);
    Imem_Rvalid   = rv;
    Imem_Rdata    = d;
    #1;
    chk("inst_ready", 32'(Inst_Ready), 32'(mbuf));
    exp_req = !k_rst && !pending && Inst_Req && !fl && (!mbuf || !Stall);
    chk("imem_req", 32'(Imem_Req), 32'(exp_req));
    if (Imem_Req) chk("imem_addr", Imem_Addr, {exp_pc[31:3], 3'b000});
    last_grant = 1'b0;
    if (k_rst) begin
      pending = 1'b0;
      mbuf    = 1'b0;
      exp_pc  = RST_PC;
    end else begin
      accepted = 1'b0;
      if (rv) begin
        if (!(pend_stale || fl)) begin
          q.push_back('{pc: exp_pc, i0: d[31:0], i1: d[63:32], v0: !exp_pc[2]});
          exp_pc   = {exp_pc[31:3] + 29'd1, 3'b000};
          accepted = 1'b1;
        end
        pending = 1'b0;
      end else if (pending && fl) begin
        pend_stale = 1'b1;
      end
      if (fl && sel == 3'b001) exp_pc = tgt;
      if (fl) mbuf = 1'b0;
      else if (accepted) mbuf = 1'b1;
      else if (mbuf && !Stall) mbuf = 1'b0;
      if (Imem_Req && Imem_Gnt) begin
        pending    = 1'b1;
        pend_stale = 1'b0;
        pend_cnt   = int'($urandom_range(k_lat_max, k_lat_min)) - 1;
        last_grant = 1'b1;
      end
    end
  endtask

  task automatic wait_grant();
    for (int i = 0; i < 50; i++) begin
      step();
      if (last_grant) return;
    end
    chk("grant_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    k_rst = 1'b1;
    step();
    step();
    chk("rst_ready", 32'(Inst_Ready), 32'd0);
    chk("rst_valids", {30'd0, Inst1_Valid, Inst0_Valid}, 32'd0);
    chk("rst_inst_pc", Inst_PC, RST_PC);
    chk("rst_addr", Imem_Addr, RST_PC);
    k_rst = 1'b0;
  endtask

  // Monitor: a new buffer load shows up as Inst_Ready rising (the buffer is always empty while a fetch is out).
  initial begin
    bit p_ready, p_stall, p_flush, p_rst;
    p_ready = 1'b0;
    forever begin
      @(posedge clk);
      p_stall = Stall;
      p_flush = Branch_Flush;
      p_rst   = rst;
      #1;
      if (Inst_Ready === 1'b1 && !p_ready) begin
        chk("load_expected", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          cur = q.pop_front();
          chk("inst_pc", Inst_PC, cur.pc);
          chk("inst0_valid", 32'(Inst0_Valid), 32'(cur.v0));
          chk("inst1_valid", 32'(Inst1_Valid), 32'd1);
          if (cur.v0) chk("inst0", Inst0, cur.i0);
          chk("inst1", Inst1, cur.i1);
        end
      end else if (Inst_Ready === 1'b1 && p_ready && p_stall && !p_flush && !p_rst) begin
        chk("hold_pc", Inst_PC, cur.pc);
        chk("hold_inst1", Inst1, cur.i1);
        chk("hold_v0", 32'(Inst0_Valid), 32'(cur.v0));
      end
      p_ready = (Inst_Ready === 1'b1);
    end
  end

  initial begin
    do_reset();
    // First fetches from RESET_PC with fixed data and one-cycle latency
    k_req = 1'b1; k_gnt_pct = 100; k_lat_min = 1; k_lat_max = 1;
    k_fixed = 1'b1; k_data = {32'h2222_2222, 32'h1111_1111};
    repeat (6) step();
    // Hold a full buffer under Stall, then release
    k_fixed = 1'b0;
    wait_grant();
    k_stall = 1'b1;
    repeat (7) step();
    k_stall = 1'b0;
    repeat (3) step();
    // Flush to 0x204 while a slow fetch is outstanding
    k_lat_min = 4; k_lat_max = 4;
    wait_grant();
    k_sel = 3'b001; k_tgt = 32'h0000_0204; k_flush_next = 1'b1;
    repeat (12) step();
    // Flush coinciding with the response
    k_lat_min = 2; k_lat_max = 2;
    wait_grant();
    k_tgt = 32'h0000_0400; k_flush_at_rv = 1'b1;
    repeat (6) step();
    // Flush with a non-branch select leaves the PC alone
    k_sel = 3'b010; k_tgt = 32'h0000_0800; k_flush_next = 1'b1;
    repeat (5) step();
    // Address wrap at the top of memory
    k_lat_min = 1; k_lat_max = 1;
    k_sel = 3'b001; k_tgt = 32'hFFFF_FFF8; k_flush_next = 1'b1;
    repeat (8) step();
    // Inst_Req drops while a fetch is outstanding
    k_lat_min = 3; k_lat_max = 3;
    wait_grant();
    k_req = 1'b0;
    repeat (6) step();
    k_req = 1'b1;
    repeat (3) step();
    // Reset in the middle of an outstanding fetch
    wait_grant();
    do_reset();
    repeat (4) step();
    // Randomised traffic
    k_rand = 1'b1; k_gnt_pct = 70; k_lat_min = 1; k_lat_max = 4;
    repeat (600) step();
    k_rand = 1'b0; k_stall = 1'b0; k_req = 1'b0;
    repeat (12) step();
    chk("queue_empty", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
